// File: rtl/spi_msg_encoder_pkg.sv
// spi_msg_encoder_pkg: shared FSM state type and checksum width for the SPI message encoder
package spi_msg_encoder_pkg;
    localparam int CSUM_W = 8;
    typedef enum logic [2:0] {IDLE, HDR, ID, LEN, PAY, CSUM} state_t;
endpackage

// File: rtl/spi_msg_encoder_if.sv
// spi_msg_encoder_if: FIFO drain and tx byte-stream signals between the SPI channels, encoder and host tx
//   have_msg/len/out_data: per-channel FIFO status and show-ahead head byte, channel i at [8i+7:8i]
//   enc_rdreq: per-channel pop strobe; tx_data/tx_valid/tx_ready: byte stream; busy: encoder not idle
//   master: encoder side; slave: channel/host side
interface spi_msg_encoder_if #(parameter int NUM_CH = 4);
    logic [NUM_CH-1:0] have_msg, enc_rdreq;
    logic [8*NUM_CH-1:0] len, out_data;
    logic [7:0] tx_data;
    logic tx_valid, tx_ready, busy;
    modport master(input have_msg, len, out_data, tx_ready, output enc_rdreq, tx_data, tx_valid, busy);
    modport slave(output have_msg, len, out_data, tx_ready, input enc_rdreq, tx_data, tx_valid, busy);
endinterface

// File: rtl/spi_msg_encoder_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, with wrap
//   req: request vector; ptr: search start; gnt: one-hot grant (zero if no request); idx: granted index
module rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [PW-1:0]     idx
);
    logic [PW-1:0] c;
    always_comb begin
        idx = '0;
        gnt = '0;
        c = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            c = PW'((int'(ptr) + k) % NUM_CH);
            if (req[c]) idx = c;
        end
        gnt[idx] = |req;
    end
endmodule

// File: rtl/spi_msg_encoder.sv
// spi_msg_encoder: frames round-robin-selected SPI channel FIFO contents into SYNC/ID/LEN/payload/CSUM packets
//   sys_clk, rst: clock and synchronous active-high reset
//   bus (master): have_msg/len/out_data in, enc_rdreq out, tx_data/tx_valid out, tx_ready in, busy out
module spi_msg_encoder
    import spi_msg_encoder_pkg::*;
#(
    parameter int         NUM_CH      = 4,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         MAX_PAYLOAD = 64,
    parameter logic [7:0] CH_ID_BASE  = 8'h10
) (
    input logic sys_clk,
    input logic rst,
    spi_msg_encoder_if.master bus
);
    localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    state_t state, nxt;
    logic [PW-1:0] sel, rr_ptr, g_idx;
    logic [NUM_CH-1:0] g_onehot;
    logic [CSUM_W-1:0] acc;
    logic [7:0] cnt, g_len, g_cap, head, ch_id;
    logic g_any, act, fire;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (.req(bus.have_msg), .ptr(rr_ptr), .gnt(g_onehot), .idx(g_idx));

    // outputs are forced low while rst is high so an abandoned packet cannot pop another byte
    always_comb begin
        g_any = |g_onehot;
        g_len = bus.len[8*int'(g_idx) +: 8];
        g_cap = g_len > 8'(MAX_PAYLOAD) ? 8'(MAX_PAYLOAD) : g_len;
        head = bus.out_data[8*int'(sel) +: 8];
        ch_id = CH_ID_BASE + 8'(sel);
        act = state != IDLE && !rst;
        fire = act && bus.tx_ready;
        bus.tx_valid = act;
        bus.busy = act;
        bus.tx_data = !act ? 8'h00 : state == HDR ? SYNC_BYTE : state == ID ? ch_id :
                      state == LEN ? cnt : state == PAY ? head : acc;
        bus.enc_rdreq = '0;
        bus.enc_rdreq[sel] = state == PAY && fire;
        nxt = state;
        case (state)
            IDLE: nxt = g_any && g_cap != 8'd0 ? HDR : IDLE;
            HDR:  nxt = fire ? ID : HDR;
            ID:   nxt = fire ? LEN : ID;
            LEN:  nxt = fire ? PAY : LEN;
            PAY:  nxt = fire && cnt == 8'd1 ? CSUM : PAY;
            CSUM: nxt = fire ? IDLE : CSUM;
            default: nxt = IDLE;
        endcase
    end

    // the accumulator is seeded with CH_ID + LEN at grant time and then absorbs each accepted payload byte
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            sel <= '0;
            cnt <= '0;
            acc <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && g_any) begin
                sel <= g_idx;
                cnt <= g_cap;
                rr_ptr <= g_idx == PW'(NUM_CH - 1) ? '0 : PW'(g_idx + 1'b1);
                acc <= CH_ID_BASE + 8'(g_idx) + g_cap;
            end else if (state == PAY && fire) begin
                cnt <= cnt - 8'd1;
                acc <= acc + head;
            end
        end
    end
endmodule

// File: tb/tb_spi_msg_encoder.sv
// tb_spi_msg_encoder: FIFO-backed channel model plus packet scoreboard checking the encoder every cycle
module tb_spi_msg_encoder;
    localparam int N = 4;
    localparam int MAXP = 64;
    typedef struct { logic [7:0] b; int ch; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_msg_encoder_if #(.NUM_CH(N)) bus();
    spi_msg_encoder #(.NUM_CH(N), .SYNC_BYTE(8'hA5), .MAX_PAYLOAD(MAXP), .CH_ID_BASE(8'h10)) dut (
        .sys_clk(clk), .rst(rst), .bus(bus));

    logic [7:0] fifo [N][$];
    exp_t exp_q[$];
    exp_t e_cur;
    logic [7:0] got[$], dq[$], lit[$];
    int pop_cnt [N];
    logic [N-1:0] pop_mask = '0;
    logic [N-1:0] ghost = '0;
    logic stall_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int checks = 0;
    int errors = 0;
    int n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: condition not met within bound", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic refresh();
        logic [N-1:0] h;
        logic [8*N-1:0] l, d;
        h = '0;
        l = '0;
        d = '0;
        for (int c = 0; c < N; c++) begin
            h[c] = fifo[c].size() != 0 || ghost[c];
            l[8*c +: 8] = ghost[c] ? 8'd0 : fifo[c].size() > 255 ? 8'd255 : 8'(fifo[c].size());
            if (fifo[c].size() != 0) d[8*c +: 8] = fifo[c][0];
        end
        bus.have_msg = h;
        bus.len = l;
        bus.out_data = d;
    endtask

    // packets a message must produce: split at MAXP, each SYNC, ID, LEN, payload, (ID+LEN+payload) mod 256
    task automatic expect_msg(input int ch, input logic [7:0] d[$]);
        int i, m;
        logic [7:0] id, s;
        i = 0;
        id = 8'h10 + 8'(ch);
        while (i < d.size()) begin
            m = d.size() - i > MAXP ? MAXP : d.size() - i;
            s = id + 8'(m);
            exp_q.push_back('{8'hA5, -1});
            exp_q.push_back('{id, -1});
            exp_q.push_back('{8'(m), -1});
            for (int k = 0; k < m; k++) begin
                exp_q.push_back('{d[i+k], ch});
                s = s + d[i+k];
            end
            exp_q.push_back('{s, -1});
            i += m;
        end
    endtask

    task automatic fill(input int ch, input logic [7:0] d[$]);
        foreach (d[k]) fifo[ch].push_back(d[k]);
    endtask

    task automatic load(input int ch, input logic [7:0] d[$]);
        expect_msg(ch, d);
        fill(ch, d);
    endtask

    task automatic clear_pops();
        for (int c = 0; c < N; c++) pop_cnt[c] = 0;
    endtask

    task automatic wait_done(input bit rnd);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.busy) && t < 2000) begin
            if (rnd) bus.tx_ready = 1'($urandom_range(0, 1));
            tick();
            t++;
        end
        bus.tx_ready = 1'b1;
        if (t >= 2000) fail_now("drain_timeout");
        tick();
    endtask

    always @(posedge clk) begin
        #1;
        for (int c = 0; c < N; c++) if (pop_mask[c] && fifo[c].size() != 0) void'(fifo[c].pop_front());
        pop_mask = '0;
        refresh();
    end

    always @(negedge clk) begin
        if (stall_prev && !rst) begin
            chk("hold_valid", 32'(bus.tx_valid), 32'd1);
            chk("hold_data", 32'(bus.tx_data), 32'(prev_data));
        end
        if (bus.tx_valid && bus.tx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: actual %0h required none", bus.tx_data);
            end else begin
                e_cur = exp_q.pop_front();
                got.push_back(bus.tx_data);
                chk("tx_data", 32'(bus.tx_data), 32'(e_cur.b));
                chk("enc_rdreq", 32'(bus.enc_rdreq), e_cur.ch >= 0 ? 32'(1 << e_cur.ch) : 32'd0);
            end
        end else begin
            chk("no_pop", 32'(bus.enc_rdreq), 32'd0);
        end
        for (int c = 0; c < N; c++) if (bus.enc_rdreq[c]) begin
            pop_cnt[c]++;
            if (fifo[c].size() == 0) fail_now("fifo_overread");
        end
        pop_mask = bus.enc_rdreq;
        stall_prev = bus.tx_valid && !bus.tx_ready && !rst;
        prev_data = bus.tx_data;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.tx_ready = 1'b1;
        refresh();
        repeat (3) tick();
        chk("rst_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rdreq", 32'(bus.enc_rdreq), 32'd0);
        chk("rst_data", 32'(bus.tx_data), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(bus.busy), 32'd0);

        got.delete();
        clear_pops();
        dq = '{8'h01, 8'h02, 8'h03};
        load(2, dq);
        refresh();
        wait_done(1'b0);
        lit = '{8'hA5, 8'h12, 8'h03, 8'h01, 8'h02, 8'h03, 8'h1B};
        chk("t1_count", 32'(got.size()), 32'd7);
        if (got.size() == 7) foreach (lit[i]) chk("t1_byte", 32'(got[i]), 32'(lit[i]));
        chk("t1_pops_ch2", 32'(pop_cnt[2]), 32'd3);
        chk("t1_pops_other", 32'(pop_cnt[0] + pop_cnt[1] + pop_cnt[3]), 32'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        got.delete();
        dq = '{8'h01};
        load(0, dq);
        dq = '{8'h02};
        load(3, dq);
        refresh();
        repeat (3) tick();
        dq = '{8'h03};
        expect_msg(0, dq);
        fill(0, dq);
        refresh();
        wait_done(1'b0);
        chk("t2_count", 32'(got.size()), 32'd15);
        if (got.size() == 15) begin
            chk("t2_first_id", 32'(got[1]), 32'h10);
            chk("t2_second_id", 32'(got[6]), 32'h13);
            chk("t2_third_id", 32'(got[11]), 32'h10);
        end

        got.delete();
        clear_pops();
        dq.delete();
        for (int i = 0; i < 100; i++) dq.push_back(8'(i * 3 + 1));
        load(1, dq);
        refresh();
        wait_done(1'b0);
        chk("t3_count", 32'(got.size()), 32'd108);
        if (got.size() == 108) begin
            chk("t3_len1", 32'(got[2]), 32'h40);
            chk("t3_len2", 32'(got[70]), 32'h24);
        end
        chk("t3_pops", 32'(pop_cnt[1]), 32'd100);

        got.delete();
        dq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        load(2, dq);
        refresh();
        wait_done(1'b1);
        chk("t4_count", 32'(got.size()), 32'd9);
        if (got.size() == 9) chk("t4_csum", 32'(got[8]), 32'h16);

        got.delete();
        clear_pops();
        dq = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
        load(3, dq);
        refresh();
        n = 0;
        while (pop_cnt[3] < 2 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) fail_now("t5_pop_wait");
        rst = 1'b1;
        exp_q.delete();
        got.delete();
        tick();
        rst = 1'b0;
        chk("t5_valid", 32'(bus.tx_valid), 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_rdreq", 32'(bus.enc_rdreq), 32'd0);
        chk("t5_data", 32'(bus.tx_data), 32'd0);
        chk("t5_left", 32'(fifo[3].size()), 32'd3);
        dq = '{8'hB3, 8'hB4, 8'hB5};
        expect_msg(3, dq);
        wait_done(1'b0);
        chk("t5_count", 32'(got.size()), 32'd7);
        if (got.size() == 7) begin
            chk("t5_len", 32'(got[2]), 32'h03);
            chk("t5_head", 32'(got[3]), 32'hB3);
        end

        got.delete();
        clear_pops();
        ghost = 4'b0010;
        refresh();
        tick();
        ghost = '0;
        refresh();
        tick();
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_nopops", 32'(pop_cnt[1]), 32'd0);
        chk("t6_nobytes", 32'(got.size()), 32'd0);
        dq = '{8'h77};
        load(0, dq);
        dq = '{8'h88};
        exp_q.delete();
        expect_msg(2, dq);
        dq = '{8'h77};
        expect_msg(0, dq);
        dq = '{8'h88};
        fill(2, dq);
        refresh();
        wait_done(1'b0);
        chk("t6_count", 32'(got.size()), 32'd10);
        if (got.size() == 10) begin
            chk("t6_first_id", 32'(got[1]), 32'h12);
            chk("t6_second_id", 32'(got[6]), 32'h10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
